// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_timer.sv
// lsu_timer: bus-wait counter for the load/store unit. Cleared when a new
// request is accepted, advanced on every REQ cycle without an ack, and flags
// expiry on the cycle that would complete the TIMEOUT_CYCLES-th wait.
module lsu_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Wait counter: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Expiry only when this cycle is another ack-less wait that reaches the limit,
  // so an ack on the final cycle always wins.
  assign expire = inc && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the register datapath and the data-memory bus.
// One word access per request, valid/ack handshake on the bus, registered
// load data and a busy stall for the sequencer.
// Optional bus timeout and sticky fault flag: define LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W         = LSU_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              fault,
  input  logic              fault_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t state;
  lsu_state_t state_next;
  logic       accept;
  logic       timeout;

  assign accept = (state == IDLE) && req_valid;

`ifdef LSU_TIMEOUT_EN
  lsu_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .inc    ((state == REQ) && !mem_ack),
    .expire (timeout)
  );

  // Sticky fault flag; a clear in the same cycle as a timeout wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end else if (timeout) begin
      fault <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  // Without the timeout feature there is nothing to flag; this is 0 for any
  // legal TIMEOUT_CYCLES and fault_clr has no effect.
  assign fault   = fault_clr & (TIMEOUT_CYCLES < 1);
`endif

  // State register; reset drops mem_req at once because it decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; acks outside REQ are ignored.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack || timeout) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus request registers, loaded only on acceptance so they stay stable in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      mem_we    <= req_we;
      mem_addr  <= req_addr;
      mem_wdata <= req_wdata;
    end
  end

  // Load data: updated only by an acked load, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data <= '0;
    end else if ((state == REQ) && mem_ack && !mem_we) begin
      ld_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. Bus responses are generated by the
// bench; expected values come from a transaction-level model (last loaded
// word, fault flag, ack latency). Build with LSU_TIMEOUT_EN to cover the timeout.
module tb_lsu;

  localparam int W = 32;
`ifdef LSU_TIMEOUT_EN
  localparam int TO      = 3;
  localparam int STORE_K = 3;
`else
  localparam int TO      = 255;
  localparam int STORE_K = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [W-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         done;
  logic [W-1:0] ld_data;
  logic         busy;
  logic         fault;
  logic         fault_clr = 1'b0;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ack = 1'b0;
  logic [W-1:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] exp_ld = '0;
  logic         exp_fault = 1'b0;

  lsu #(.DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .ld_data(ld_data), .busy(busy),
    .fault(fault), .fault_clr(fault_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One access: ack arrives in REQ cycle k (k>=1). Optionally keep ack high in DONE.
  task automatic access(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                        input logic [W-1:0] rdata, input int k, input bit ack_in_done);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom(); req_addr = $urandom(); req_wdata = $urandom();
    for (int i = 1; i <= k; i++) begin
      tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, busy, done, req_ready} !==
          {1'b1, we, addr, wdata, 1'b1, 1'b0, 1'b0}) begin
        fails++;
        $display("[TB] FAIL req_cycle%0d: got req=%b we=%b addr=%h wdata=%h busy=%b done=%b ready=%b, want req=1 we=%b addr=%h wdata=%h busy=1 done=0 ready=0",
                 i, mem_req, mem_we, mem_addr, mem_wdata, busy, done, req_ready, we, addr, wdata);
      end
      mem_ack   = (i == k);
      mem_rdata = (i == k) ? rdata : $urandom();
      @(negedge clk);
    end
    if (!we) exp_ld = rdata;
    mem_ack   = ack_in_done;
    mem_rdata = $urandom();
    tests++;
    if ({mem_req, busy, done, req_ready, ld_data, fault} !== {1'b0, 1'b1, 1'b1, 1'b0, exp_ld, exp_fault}) begin
      fails++;
      $display("[TB] FAIL done_cycle: got req=%b busy=%b done=%b ready=%b ld=%h fault=%b, want 0 1 1 0 ld=%h fault=%b",
               mem_req, busy, done, req_ready, ld_data, fault, exp_ld, exp_fault);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({mem_req, busy, done, req_ready, ld_data} !== {1'b0, 1'b0, 1'b0, 1'b1, exp_ld}) begin
      fails++;
      $display("[TB] FAIL after_done: got req=%b busy=%b done=%b ready=%b ld=%h, want 0 0 0 1 ld=%h",
               mem_req, busy, done, req_ready, ld_data, exp_ld);
    end
    $display("[TB] %s addr=%h wdata=%h rdata=%h ack_cycle=%0d ld_data=%h",
             we ? "store" : "load ", addr, wdata, rdata, k, ld_data);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({req_ready, busy, done, mem_req, mem_we, mem_addr, mem_wdata, ld_data, fault} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_values: got ready=%b busy=%b done=%b req=%b we=%b addr=%h wdata=%h ld=%h fault=%b, want 1 0 0 0 0 0 0 0 0",
               req_ready, busy, done, mem_req, mem_we, mem_addr, mem_wdata, ld_data, fault);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({req_ready, busy, done, mem_req} !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL reset_release: got ready=%b busy=%b done=%b req=%b, want 1 0 0 0",
               req_ready, busy, done, mem_req);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_load_first();
    access(1'b0, 32'h10, $urandom(), 32'hDEADBEEF, 1, 1'b0);
  endtask

  task automatic test_store_delayed();
    access(1'b1, 32'h20, 32'h12345678, $urandom(), STORE_K, 1'b0);
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = $urandom();
      @(negedge clk);
      tests++;
      if ({mem_req, busy, done, req_ready, ld_data} !== {1'b0, 1'b0, 1'b0, 1'b1, exp_ld}) begin
        fails++;
        $display("[TB] FAIL spurious_idle%0d: got req=%b busy=%b done=%b ready=%b ld=%h, want 0 0 0 1 ld=%h",
                 i, mem_req, busy, done, req_ready, ld_data, exp_ld);
      end
      mem_ack = 1'b0;
    end
    $display("[TB] spurious ack in IDLE ld_data=%h", ld_data);
    // Ack kept high into DONE must not reload ld_data.
    access(1'b0, $urandom(), $urandom(), $urandom(), 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    access(1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 1, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h48;
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reset_pre: got mem_req=%b, want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_ld = '0;
    tests++;
    if ({mem_req, busy, req_ready, done, ld_data, mem_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
      fails++;
      $display("[TB] FAIL mid_reset_async: got req=%b busy=%b ready=%b done=%b ld=%h addr=%h, want 0 0 1 0 0 0",
               mem_req, busy, req_ready, done, ld_data, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({done, mem_req, busy} !== 3'b000) begin
        fails++;
        $display("[TB] FAIL mid_reset_nodone%0d: got done=%b req=%b busy=%b, want 0 0 0", i, done, mem_req, busy);
      end
    end
    $display("[TB] reset during REQ abandoned access");
    access(1'b0, 32'h4C, 32'h0, 32'h0BADC0DE, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      access(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), $urandom_range(1, 3), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r1, r2;
    r1 = $urandom(); r2 = $urandom();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    @(negedge clk);
    tests++;
    if ({mem_req, mem_addr, req_ready} !== {1'b1, 32'h100, 1'b0}) begin
      fails++;
      $display("[TB] FAIL b2b_first_req: got req=%b addr=%h ready=%b, want 1 00000100 0", mem_req, mem_addr, req_ready);
    end
    req_addr = 32'h104; mem_ack = 1'b1; mem_rdata = r1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom();
    exp_ld = r1;
    tests++;
    if ({done, ld_data, req_ready, mem_req} !== {1'b1, exp_ld, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL b2b_first_done: got done=%b ld=%h ready=%b req=%b, want 1 %h 0 0", done, ld_data, req_ready, mem_req, exp_ld);
    end
    @(negedge clk);
    tests++;
    if ({done, req_ready, mem_req} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL b2b_gap: got done=%b ready=%b req=%b, want 0 1 0", done, req_ready, mem_req);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin
      fails++;
      $display("[TB] FAIL b2b_second_accept: got req=%b addr=%h, want 1 00000104", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = r2;
    @(negedge clk);
    mem_ack = 1'b0;
    exp_ld = r2;
    tests++;
    if ({done, ld_data} !== {1'b1, exp_ld}) begin
      fails++;
      $display("[TB] FAIL b2b_second_done: got done=%b ld=%h, want 1 %h", done, ld_data, exp_ld);
    end
    @(negedge clk);
    $display("[TB] back-to-back loads ld1=%h ld2=%h", r1, r2);
  endtask

`ifdef LSU_TIMEOUT_EN
  // Load with no ack; clr_held keeps fault_clr high across the expiry edge.
  task automatic timeout_run(input bit clr_held);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = $urandom();
    @(negedge clk);
    req_valid = 1'b0;
    fault_clr = clr_held;
    for (int i = 1; i <= TO; i++) begin
      tests++;
      if ({mem_req, done} !== 2'b10) begin
        fails++;
        $display("[TB] FAIL timeout_wait%0d: got req=%b done=%b, want 1 0", i, mem_req, done);
      end
      @(negedge clk);
    end
    fault_clr = 1'b0;
    exp_fault = !clr_held;
    tests++;
    if ({mem_req, done, fault, ld_data} !== {1'b0, 1'b1, exp_fault, exp_ld}) begin
      fails++;
      $display("[TB] FAIL timeout_done: got req=%b done=%b fault=%b ld=%h, want 0 1 %b %h",
               mem_req, done, fault, ld_data, exp_fault, exp_ld);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({fault, done, req_ready} !== {exp_fault, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL timeout_sticky: got fault=%b done=%b ready=%b, want %b 0 1", fault, done, req_ready, exp_fault);
    end
    $display("[TB] timeout clr_held=%0d fault=%b", clr_held, fault);
  endtask

  task automatic test_timeout();
    timeout_run(1'b0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    exp_fault = 1'b0;
    tests++;
    if (fault !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fault_clr: got fault=%b, want 0", fault);
    end
    access(1'b0, $urandom(), $urandom(), 32'hA5A5_0003, TO, 1'b0);
    timeout_run(1'b1);
  endtask
`else
  task automatic test_timeout();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fault_clr = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests++;
      if (fault !== 1'b0) begin
        fails++;
        $display("[TB] FAIL fault_tied%0d: got fault=%b, want 0", i, fault);
      end
    end
    fault_clr = 1'b0;
    $display("[TB] fault tied low without timeout feature");
  endtask
`endif

  initial begin
    test_reset();
    test_load_first();
    test_store_delayed();
    test_spurious_ack();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
